// File: rtl/demux1_16_8b_tdm_pkg.sv
// Shared definitions for the 1:16 TDM byte demultiplexer: FSM encoding and channel geometry.
package demux1_16_8b_tdm_pkg;

    localparam int NCH = 16;
    localparam int CHW = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } state_e;

endpackage

// File: rtl/demux1_16_8b_tdm_if.sv
// Byte-stream input and 16-channel output bundle of the TDM demultiplexer.
interface demux1_16_8b_tdm_if #(
    parameter int W = 8
);
    logic [W-1:0] D;
    logic         valid;
    logic         sof;
    logic         sel3, sel2, sel1, sel0;
    logic [W-1:0] Y_0, Y_1, Y_2, Y_3, Y_4, Y_5, Y_6, Y_7;
    logic [W-1:0] Y_8, Y_9, Y_10, Y_11, Y_12, Y_13, Y_14, Y_15;
    logic [15:0]  Y_strb;
    logic [3:0]   ch;
    logic         busy;
    logic         frame_done;
    logic         err;

    modport master (
        output D, valid, sof, sel3, sel2, sel1, sel0,
        input  Y_0, Y_1, Y_2, Y_3, Y_4, Y_5, Y_6, Y_7,
        input  Y_8, Y_9, Y_10, Y_11, Y_12, Y_13, Y_14, Y_15,
        input  Y_strb, ch, busy, frame_done, err
    );

    modport slave (
        input  D, valid, sof, sel3, sel2, sel1, sel0,
        output Y_0, Y_1, Y_2, Y_3, Y_4, Y_5, Y_6, Y_7,
        output Y_8, Y_9, Y_10, Y_11, Y_12, Y_13, Y_14, Y_15,
        output Y_strb, ch, busy, frame_done, err
    );
endinterface

// File: rtl/demux1_16_8b_tdm_dec.sv
// 4->16 one-hot decoder with enable; selects which output register takes the current byte.
module dec4_16_en
    import demux1_16_8b_tdm_pkg::*;
(
    input  logic           en,
    input  logic [CHW-1:0] sel,
    output logic [NCH-1:0] y
);
    always_comb begin
        // NOTE: give every combinational output a default before any branch so no latch is inferred.
        y = '0;
        if (en) y[sel] = 1'b1;
    end
endmodule

// File: rtl/demux1_16_8b_tdm.sv
// Receive side of the 16:1 byte TDM link: spreads a framed byte stream over 16 registered outputs.
module demux1_16_8b_tdm
    import demux1_16_8b_tdm_pkg::*;
#(
    parameter int W       = 8,
    parameter int TIMEOUT = 32
) (
    input  logic                clk,
    input  logic                rst,
    demux1_16_8b_tdm_if.slave   bus
);
    localparam int IDLE_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = (TIMEOUT > 0) ? IDLE_W'(TIMEOUT - 1) : '0;

    state_e            state_q, state_d;
    logic [CHW-1:0]    ch_q, ch_d;
    logic [CHW-1:0]    cnt_q, cnt_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [NCH-1:0]    strb_q, strb_d;
    logic [W-1:0]      y_q [NCH];
    logic [W-1:0]      y_d [NCH];

    logic              wr_en;
    logic [CHW-1:0]    wr_ch;
    logic [CHW-1:0]    sel_s;
    logic              timeout_hit;

    assign sel_s       = {bus.sel3, bus.sel2, bus.sel1, bus.sel0};
    assign timeout_hit = (TIMEOUT != 0) && (idle_q == IDLE_LAST);

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        cnt_d   = cnt_q;
        idle_d  = idle_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        wr_en   = 1'b0;
        wr_ch   = ch_q;

        if (bus.valid) begin
            idle_d = '0;
            if (bus.sof) begin
                // A sof always opens a new frame; inside FILL it also aborts the old one.
                wr_en   = 1'b1;
                wr_ch   = sel_s;
                ch_d    = sel_s + 4'd1;
                cnt_d   = 4'd1;
                state_d = ST_FILL;
                err_d   = (state_q == ST_FILL);
            end else if (state_q == ST_FILL) begin
                wr_en = 1'b1;
                ch_d  = ch_q + 4'd1;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
        end else if (state_q == ST_FILL) begin
            if (timeout_hit) begin
                err_d   = 1'b1;
                state_d = ST_IDLE;
                idle_d  = '0;
            end else if (idle_q != '1) begin
                idle_d = idle_q + 1'b1;
            end
        end
    end

    dec4_16_en u_dec (
        .en  (wr_en),
        .sel (wr_ch),
        .y   (strb_d)
    );

    always_comb begin
        for (int k = 0; k < NCH; k++) y_d[k] = strb_d[k] ? bus.D : y_q[k];
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ch_q    <= '0;
            cnt_q   <= '0;
            idle_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            strb_q  <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            cnt_q   <= cnt_d;
            idle_q  <= idle_d;
            done_q  <= done_d;
            err_q   <= err_d;
            strb_q  <= strb_d;
        end
    end

    // NOTE: the output bank is a visible register file, not scratch storage, so it is reset explicitly.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NCH; k++) begin
            if (rst) y_q[k] <= '0;
            else     y_q[k] <= y_d[k];
        end
    end

    assign bus.Y_0  = y_q[0];
    assign bus.Y_1  = y_q[1];
    assign bus.Y_2  = y_q[2];
    assign bus.Y_3  = y_q[3];
    assign bus.Y_4  = y_q[4];
    assign bus.Y_5  = y_q[5];
    assign bus.Y_6  = y_q[6];
    assign bus.Y_7  = y_q[7];
    assign bus.Y_8  = y_q[8];
    assign bus.Y_9  = y_q[9];
    assign bus.Y_10 = y_q[10];
    assign bus.Y_11 = y_q[11];
    assign bus.Y_12 = y_q[12];
    assign bus.Y_13 = y_q[13];
    assign bus.Y_14 = y_q[14];
    assign bus.Y_15 = y_q[15];

    assign bus.Y_strb     = strb_q;
    assign bus.ch         = ch_q;
    assign bus.busy       = (state_q == ST_FILL);
    assign bus.frame_done = done_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_demux1_16_8b_tdm.sv
// Directed bench for the TDM demultiplexer: per-cycle vector table plus multi-cycle frame sequences.
module tb_demux1_16_8b_tdm;
    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    demux1_16_8b_tdm_if #(.W(8)) bus ();

    demux1_16_8b_tdm #(.W(8), .TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] y_arr [16];
    assign y_arr[0]  = bus.Y_0;
    assign y_arr[1]  = bus.Y_1;
    assign y_arr[2]  = bus.Y_2;
    assign y_arr[3]  = bus.Y_3;
    assign y_arr[4]  = bus.Y_4;
    assign y_arr[5]  = bus.Y_5;
    assign y_arr[6]  = bus.Y_6;
    assign y_arr[7]  = bus.Y_7;
    assign y_arr[8]  = bus.Y_8;
    assign y_arr[9]  = bus.Y_9;
    assign y_arr[10] = bus.Y_10;
    assign y_arr[11] = bus.Y_11;
    assign y_arr[12] = bus.Y_12;
    assign y_arr[13] = bus.Y_13;
    assign y_arr[14] = bus.Y_14;
    assign y_arr[15] = bus.Y_15;

    typedef struct {
        logic       rst;
        logic       valid;
        logic       sof;
        logic [3:0] sel;
        logic [7:0] d;
        logic [15:0] strb;
        logic [3:0] ch;
        logic       busy;
        logic       done;
        logic       err;
    } vec_t;

    vec_t vecs[$];

    logic [7:0] frame [16] = '{8'h00, 8'h01, 8'hFF, 8'hFE, 8'hFD, 8'hFC, 8'h02, 8'h03,
                               8'h61, 8'h62, 8'h63, 8'h90, 8'h91, 8'h92, 8'h93, 8'hF0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic s,
                         input logic [3:0] sel, input logic [7:0] d);
        rst = r;
        bus.valid = v;
        bus.sof = s;
        {bus.sel3, bus.sel2, bus.sel1, bus.sel0} = sel;
        bus.D = d;
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_ctl(input string tag, input logic [15:0] strb, input logic [3:0] ch,
                              input logic busy, input logic done, input logic err);
        check({tag, ".strb"}, 32'(bus.Y_strb), 32'(strb));
        check({tag, ".ch"},   32'(bus.ch),     32'(ch));
        check({tag, ".busy"}, 32'(bus.busy),   32'(busy));
        check({tag, ".done"}, 32'(bus.frame_done), 32'(done));
        check({tag, ".err"},  32'(bus.err),    32'(err));
    endtask

    function automatic vec_t mk(logic r, logic v, logic s, logic [3:0] sel, logic [7:0] d,
                                logic [15:0] strb, logic [3:0] ch, logic busy, logic done, logic err);
        vec_t t;
        t.rst = r; t.valid = v; t.sof = s; t.sel = sel; t.d = d;
        t.strb = strb; t.ch = ch; t.busy = busy; t.done = done; t.err = err;
        return t;
    endfunction

    initial begin
        int done_cnt;
        drive(1'b1, 1'b1, 1'b1, 4'd5, 8'hAA);

        // Reset with valid/sof asserted, a dropped byte in IDLE, then a full frame from S=0.
        vecs.push_back(mk(1, 1, 1, 4'd5, 8'hAA, 16'h0, 4'd0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 4'd5, 8'hAA, 16'h0, 4'd0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 4'd0, 8'h77, 16'h0, 4'd0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 4'd0, 8'h77, 16'h0, 4'd0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 4'd0, 8'h00, 16'h0001, 4'd1,  1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 4'd0, 8'h01, 16'h0002, 4'd2,  1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 4'd0, 8'hFF, 16'h0004, 4'd3,  1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 4'd0, 8'hFE, 16'h0008, 4'd4,  1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 4'd0, 8'hFD, 16'h0010, 4'd5,  1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 4'd0, 8'hFC, 16'h0020, 4'd6,  1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 4'd0, 8'h02, 16'h0040, 4'd7,  1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 4'd0, 8'h03, 16'h0080, 4'd8,  1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 4'd0, 8'h61, 16'h0100, 4'd9,  1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 4'd0, 8'h62, 16'h0200, 4'd10, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 4'd0, 8'h63, 16'h0400, 4'd11, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 4'd0, 8'h90, 16'h0800, 4'd12, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 4'd0, 8'h91, 16'h1000, 4'd13, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 4'd0, 8'h92, 16'h2000, 4'd14, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 4'd0, 8'h93, 16'h4000, 4'd15, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 4'd0, 8'hF0, 16'h8000, 4'd0,  0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 4'd0, 8'h00, 16'h0000, 4'd0,  0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].valid, vecs[i].sof, vecs[i].sel, vecs[i].d);
            step();
            expect_ctl($sformatf("vec%0d", i), vecs[i].strb, vecs[i].ch,
                       vecs[i].busy, vecs[i].done, vecs[i].err);
            if (i == 1) begin
                for (int k = 0; k < 16; k++) check($sformatf("rst.Y_%0d", k), 32'(y_arr[k]), 32'h0);
            end
        end
        for (int k = 0; k < 16; k++) check($sformatf("full.Y_%0d", k), 32'(y_arr[k]), 32'(frame[k]));

        // Wrap: start at channel 13, bytes A0..AF.
        for (int i = 0; i < 16; i++) begin
            logic [7:0] d;
            logic [3:0] c;
            d = 8'hA0 + 8'(i);
            c = 4'(13 + i);
            drive(0, 1, (i == 0), 4'b1101, d);
            step();
            expect_ctl($sformatf("wrap%0d", i), 16'(1) << c, c + 4'd1,
                       (i != 15), (i == 15), 1'b0);
        end
        check("wrap.Y_13", 32'(bus.Y_13), 32'hA0);
        check("wrap.Y_14", 32'(bus.Y_14), 32'hA1);
        check("wrap.Y_15", 32'(bus.Y_15), 32'hA2);
        check("wrap.Y_0",  32'(bus.Y_0),  32'hA3);
        check("wrap.Y_12", 32'(bus.Y_12), 32'hAF);

        // Early sof: five bytes from S=0, then a sof to channel 7.
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, (i == 0), 4'd0, 8'hB0 + 8'(i));
            step();
        end
        check("early.ch5", 32'(bus.ch), 32'd5);
        drive(0, 1, 1, 4'b0111, 8'h55);
        step();
        expect_ctl("early.abort", 16'h0080, 4'd8, 1'b1, 1'b0, 1'b1);
        check("early.Y_7", 32'(bus.Y_7), 32'h55);
        for (int k = 0; k < 5; k++) check($sformatf("early.Y_%0d", k), 32'(y_arr[k]), 32'hB0 + 32'(k));
        drive(0, 0, 0, 4'd0, 8'h00);
        step();
        check("early.err_clear", 32'(bus.err), 32'd0);

        // Timeout: reset, three bytes, four idle cycles, then a dropped byte.
        drive(1, 0, 0, 4'd0, 8'h00);
        step();
        expect_ctl("to.rst", 16'h0, 4'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, (i == 0), 4'd0, 8'hC0 + 8'(i));
            step();
        end
        check("to.ch3", 32'(bus.ch), 32'd3);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 4'd0, 8'h00);
            step();
            expect_ctl($sformatf("to.idle%0d", i), 16'h0, 4'd3, (i != 3), 1'b0, (i == 3));
        end
        drive(0, 1, 0, 4'd0, 8'hEE);
        step();
        expect_ctl("to.drop", 16'h0, 4'd3, 1'b0, 1'b0, 1'b0);
        check("to.Y_3", 32'(bus.Y_3), 32'h0);
        check("to.Y_2", 32'(bus.Y_2), 32'hC2);

        // Gaps: the full frame with a one-cycle gap after every byte.
        drive(1, 0, 0, 4'd0, 8'h00);
        step();
        done_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            drive(0, 1, (i == 0), 4'd0, frame[i]);
            step();
            check($sformatf("gap.strb%0d", i), 32'(bus.Y_strb), 32'(16'(1) << i));
            if (bus.frame_done) done_cnt++;
            drive(0, 0, 0, 4'd0, 8'h5A);
            step();
            check($sformatf("gap.idle_strb%0d", i), 32'(bus.Y_strb), 32'h0);
            if (bus.frame_done) done_cnt++;
        end
        check("gap.done_cnt", 32'(done_cnt), 32'd1);
        check("gap.ch", 32'(bus.ch), 32'd0);
        check("gap.busy", 32'(bus.busy), 32'd0);
        for (int k = 0; k < 16; k++) check($sformatf("gap.Y_%0d", k), 32'(y_arr[k]), 32'(frame[k]));

        // Reset in the middle of a second frame.
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, (i == 0), 4'd0, 8'h11 * 8'(i + 1));
            step();
        end
        check("mid.busy", 32'(bus.busy), 32'd1);
        drive(1, 1, 0, 4'd0, 8'h44);
        step();
        expect_ctl("mid.rst", 16'h0, 4'd0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 16; k++) check($sformatf("mid.Y_%0d", k), 32'(y_arr[k]), 32'h0);
        drive(0, 0, 0, 4'd0, 8'h00);
        step();
        expect_ctl("mid.after", 16'h0, 4'd0, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
